i3c_axi_mgr: RTL and testbench

//  AXI manager: turns one simple component request into a single-ID INCR AXI burst.
//  It is the initiator counterpart of the AXI subordinate, used by DMA-like fabric clients.
//  One transaction is outstanding at a time.

---
 rtl/i3ccore_axi_pkg.sv | 28 ++
 rtl/axi_if.sv | 84 ++++++++
 rtl/i3c_axi_mgr.sv | 228 ++++++++++++++++++++++
 tb/tb_i3c_axi_mgr.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3ccore_axi_pkg.sv
// Shared AXI encodings and helpers for the i3c core fabric blocks.
package i3ccore_axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    // True when an INCR burst starting at this offset runs past the end of its 4KB page.
    function automatic logic axi_4k_cross(input logic [11:0] addr,
                                          input logic [7:0]  len,
                                          input logic [2:0]  size);
        logic [16:0] span;
        logic [16:0] end_off;
        span    = ({9'd0, len} + 17'd1) << size;
        end_off = {5'd0, addr} + span;
        return end_off > 17'd4096;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle split into write (AW/W/B) and read (AR/R) manager/subordinate views.
interface axi_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1
);
    localparam int BC = DW / 8;

    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awlock;
    logic [3:0]    awcache;
    logic [2:0]    awprot;
    logic [UW-1:0] awuser;
    logic          awvalid;
    logic          awready;

    logic [DW-1:0] wdata;
    logic [BC-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;

    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [UW-1:0] aruser;
    logic          arvalid;
    logic          arready;

    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport w_mgr (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport r_mgr (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport w_sub (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport r_sub (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/i3c_axi_mgr.sv
// AXI manager: turns one component request into a single-ID INCR burst with
// streamed write/read beats and a one-cycle completion pulse.
module i3c_axi_mgr
    import i3ccore_axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1
) (
    input  logic            clk,
    input  logic            rst,
    axi_if.w_mgr            m_axi_w_if,
    axi_if.r_mgr            m_axi_r_if,
    input  logic            req_dv,
    output logic            req_hld,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [7:0]      req_len,
    input  logic [2:0]      req_size,
    input  logic [UW-1:0]   req_user,
    input  logic [IW-1:0]   req_id,
    input  logic            wr_dv,
    output logic            wr_hld,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    output logic            rd_dv,
    input  logic            rd_hld,
    output logic [DW-1:0]   rdata,
    output logic            rd_last,
    output logic            resp_dv,
    output logic            resp_err
);

    localparam int         BC       = DW / 8;
    localparam int         BW       = $clog2(BC);
    localparam logic [2:0] MAX_SIZE = 3'(BW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_e;

    state_e state;
    state_e state_nxt;

    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [2:0]    size_q;
    logic [UW-1:0] user_q;
    logic [IW-1:0] id_q;
    logic          awvalid_q;
    logic          arvalid_q;
    logic          aw_done;
    logic          w_done;
    logic          err;
    logic [7:0]    beat_cnt;

    logic accept;
    logic reject;
    logic wvalid_int;
    logic wlast_int;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic r_hs;

    assign accept     = (state == S_IDLE) && req_dv;
    assign reject     = (req_size > MAX_SIZE) || axi_4k_cross(req_addr[11:0], req_len, req_size);
    assign wvalid_int = (state == S_WR) && !w_done && wr_dv;
    assign wlast_int  = (beat_cnt == len_q);
    assign aw_hs      = awvalid_q && m_axi_w_if.awready;
    assign w_hs       = wvalid_int && m_axi_w_if.wready;
    assign ar_hs      = arvalid_q && m_axi_r_if.arready;
    assign r_hs       = (state == S_RD_DATA) && m_axi_r_if.rvalid && !rd_hld;

    assign m_axi_w_if.awid    = id_q;
    assign m_axi_w_if.awaddr  = addr_q;
    assign m_axi_w_if.awlen   = len_q;
    assign m_axi_w_if.awsize  = size_q;
    assign m_axi_w_if.awburst = AXI_BURST_INCR;
    assign m_axi_w_if.awlock  = 1'b0;
    assign m_axi_w_if.awcache = 4'd0;
    assign m_axi_w_if.awprot  = 3'd0;
    assign m_axi_w_if.awuser  = user_q;
    assign m_axi_w_if.awvalid = awvalid_q;

    assign m_axi_w_if.wdata  = wdata;
    assign m_axi_w_if.wstrb  = wstrb;
    assign m_axi_w_if.wlast  = wlast_int;
    assign m_axi_w_if.wvalid = wvalid_int;

    assign m_axi_r_if.arid    = id_q;
    assign m_axi_r_if.araddr  = addr_q;
    assign m_axi_r_if.arlen   = len_q;
    assign m_axi_r_if.arsize  = size_q;
    assign m_axi_r_if.arburst = AXI_BURST_INCR;
    assign m_axi_r_if.arlock  = 1'b0;
    assign m_axi_r_if.arcache = 4'd0;
    assign m_axi_r_if.arprot  = 3'd0;
    assign m_axi_r_if.aruser  = user_q;
    assign m_axi_r_if.arvalid = arvalid_q;

    assign rdata   = m_axi_r_if.rdata;
    assign rd_last = m_axi_r_if.rlast;

    // IDs and the low response bit carry no information for a single-ID manager.
    logic unused_sigs;
    assign unused_sigs = ^{m_axi_w_if.bid, m_axi_r_if.rid, m_axi_w_if.bresp[0], m_axi_r_if.rresp[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        req_hld            = (state != S_IDLE);
        wr_hld             = !((state == S_WR) && !w_done && m_axi_w_if.wready);
        m_axi_w_if.bready  = 1'b0;
        m_axi_r_if.rready  = 1'b0;
        rd_dv              = 1'b0;
        resp_dv            = 1'b0;
        resp_err           = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_dv) begin
                    if (reject) begin
                        state_nxt = S_RESP;
                    end else if (req_write) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                // AW and W finish independently; either may be the one completing this cycle.
                if ((aw_done || aw_hs) && (w_done || (w_hs && wlast_int))) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                m_axi_w_if.bready = 1'b1;
                if (m_axi_w_if.bvalid) begin
                    state_nxt = S_RESP;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs) begin
                    state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                m_axi_r_if.rready = !rd_hld;
                rd_dv             = m_axi_r_if.rvalid;
                if (r_hs && m_axi_r_if.rlast) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_dv   = 1'b1;
                resp_err  = err;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            user_q    <= '0;
            id_q      <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            err       <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            if (accept) begin
                addr_q    <= req_addr;
                len_q     <= req_len;
                size_q    <= req_size;
                user_q    <= req_user;
                id_q      <= req_id;
                err       <= reject;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                beat_cnt  <= '0;
                awvalid_q <= !reject && req_write;
                arvalid_q <= !reject && !req_write;
            end
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                aw_done   <= 1'b1;
            end
            // The counter stops on the last beat so len=255 never wraps back to zero.
            if (w_hs) begin
                if (wlast_int) begin
                    w_done <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            if ((state == S_WR_RESP) && m_axi_w_if.bvalid) begin
                err <= m_axi_w_if.bresp[1];
            end
            if (r_hs && m_axi_r_if.rresp[1]) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i3c_axi_mgr.sv
// Scoreboard bench for i3c_axi_mgr: directed requests push expectations,
// a negedge monitor pops and compares every handshake and completion.
module tb_i3c_axi_mgr;
    import i3ccore_axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int UW = 32;
    localparam int IW = 1;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] user;
        logic        id;
        int          w_before;
    } a_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rd_exp_t;

    typedef struct {
        logic err;
        int   cyc;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic req_dv, req_hld, req_write;
    logic [AW-1:0] req_addr;
    logic [7:0] req_len;
    logic [2:0] req_size;
    logic [UW-1:0] req_user;
    logic [IW-1:0] req_id;
    logic wr_dv, wr_hld;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic rd_dv, rd_hld, rd_last, resp_dv, resp_err;
    logic [DW-1:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int w_seen = 0;
    logic prev_resp = 1'b0;

    a_exp_t    exp_aw[$];
    a_exp_t    exp_ar[$];
    w_exp_t    exp_w[$];
    rd_exp_t   exp_rd[$];
    resp_exp_t exp_resp[$];

    int          aw_delay = 0;
    int          aw_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    int          r_err_beat = -1;
    int          r_left = 0;
    int          r_idx = 0;
    logic [31:0] r_base = '0;

    axi_if #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) axi ();

    i3c_axi_mgr #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_axi_w_if (axi),
        .m_axi_r_if (axi),
        .req_dv     (req_dv),
        .req_hld    (req_hld),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_user   (req_user),
        .req_id     (req_id),
        .wr_dv      (wr_dv),
        .wr_hld     (wr_hld),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rd_dv      (rd_dv),
        .rd_hld     (rd_hld),
        .rdata      (rdata),
        .rd_last    (rd_last),
        .resp_dv    (resp_dv),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: handshake with no expected entry, expected none (cycle %0d)", name, cyc);
    endtask

    // Subordinate model: drives just after each rising edge, advances on the falling edge.
    always @(posedge clk) begin
        #1;
        axi.awready = axi.awvalid && (aw_wait >= aw_delay);
        axi.wready  = 1'b1;
        axi.bvalid  = axi.bready;
        axi.bresp   = bresp_cfg;
        axi.bid     = '0;
        axi.arready = axi.arvalid;
        axi.rvalid  = (r_left > 0);
        axi.rdata   = 32'h5A5A_0000 | (r_base + 32'(r_idx * 4));
        axi.rresp   = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
        axi.rlast   = (r_left == 1);
        axi.rid     = '0;
    end

    always @(negedge clk) begin
        if (!axi.awvalid || axi.awready) aw_wait = 0;
        else aw_wait++;
        if (axi.arvalid && axi.arready) begin
            r_left = int'(axi.arlen) + 1;
            r_idx  = 0;
            r_base = axi.araddr;
        end
        if (axi.rvalid && axi.rready) begin
            r_idx++;
            r_left--;
        end
    end

    // Monitor: every DUT handshake or completion pops one expectation.
    a_exp_t    mon_a;
    w_exp_t    mon_w;
    rd_exp_t   mon_rd;
    resp_exp_t mon_resp;
    always @(negedge clk) begin
        if (!rst) begin
            if (axi.wvalid && axi.wready) begin
                if (exp_w.size() == 0) report_unexpected("w_beat");
                else begin
                    mon_w = exp_w.pop_front();
                    check_output("wdata", 64'(axi.wdata), 64'(mon_w.data));
                    check_output("wstrb", 64'(axi.wstrb), 64'(mon_w.strb));
                    check_output("wlast", 64'(axi.wlast), 64'(mon_w.last));
                end
                w_seen++;
            end
            if (axi.awvalid && axi.awready) begin
                if (exp_aw.size() == 0) report_unexpected("aw");
                else begin
                    mon_a = exp_aw.pop_front();
                    check_output("awaddr", 64'(axi.awaddr), 64'(mon_a.addr));
                    check_output("awlen", 64'(axi.awlen), 64'(mon_a.len));
                    check_output("awsize", 64'(axi.awsize), 64'(mon_a.size));
                    check_output("awuser", 64'(axi.awuser), 64'(mon_a.user));
                    check_output("awid", 64'(axi.awid), 64'(mon_a.id));
                    check_output("awburst", 64'(axi.awburst), 64'(2'b01));
                    check_output("aw_lock_cache_prot", 64'({axi.awlock, axi.awcache, axi.awprot}), 64'(0));
                    if (mon_a.w_before >= 0) check_output("w_beats_before_aw", 64'(w_seen), 64'(mon_a.w_before));
                end
                w_seen = 0;
            end
            if (axi.arvalid && axi.arready) begin
                if (exp_ar.size() == 0) report_unexpected("ar");
                else begin
                    mon_a = exp_ar.pop_front();
                    check_output("araddr", 64'(axi.araddr), 64'(mon_a.addr));
                    check_output("arlen", 64'(axi.arlen), 64'(mon_a.len));
                    check_output("arsize", 64'(axi.arsize), 64'(mon_a.size));
                    check_output("aruser", 64'(axi.aruser), 64'(mon_a.user));
                    check_output("arburst", 64'(axi.arburst), 64'(2'b01));
                end
            end
            if (rd_hld) check_output("rready_while_hld", 64'(axi.rready), 64'(0));
            if (rd_dv && !rd_hld) begin
                if (exp_rd.size() == 0) report_unexpected("rd_beat");
                else begin
                    mon_rd = exp_rd.pop_front();
                    check_output("rdata", 64'(rdata), 64'(mon_rd.data));
                    check_output("rd_last", 64'(rd_last), 64'(mon_rd.last));
                end
            end
            if (resp_dv) begin
                if (prev_resp) report_unexpected("resp_two_cycles");
                if (exp_resp.size() == 0) report_unexpected("resp");
                else begin
                    mon_resp = exp_resp.pop_front();
                    check_output("resp_err", 64'(resp_err), 64'(mon_resp.err));
                    if (mon_resp.cyc >= 0) check_output("resp_cycle", 64'(cyc), 64'(mon_resp.cyc));
                end
            end
            prev_resp = resp_dv;
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size);
        req_dv    = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        req_size  = size;
        req_user  = 32'hCAFE_0000 | addr;
        req_id    = len[0];
        @(posedge clk);
        #1;
        req_dv    = 1'b0;
    endtask

    task automatic send_w_beat(input logic [31:0] d, input logic [3:0] s);
        int   n  = 0;
        logic hs = 1'b0;
        wr_dv = 1'b1;
        wdata = d;
        wstrb = s;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = !wr_hld;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) report_unexpected("w_beat_timeout");
    endtask

    task automatic flush_queues();
        exp_aw.delete();
        exp_ar.delete();
        exp_w.delete();
        exp_rd.delete();
        exp_resp.delete();
    endtask

    task automatic wait_resp(input int budget, input logic toggle);
        int n = 0;
        while (exp_resp.size() > 0 && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle) rd_hld = !rd_hld;
            n++;
        end
        rd_hld = 1'b0;
        if (exp_resp.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL resp_timeout: no completion after %0d cycles, expected one", budget);
            flush_queues();
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [3:0] strb, input int dly, input logic [1:0] bresp,
                            input logic exp_err, input int w_before);
        aw_delay  = dly;
        bresp_cfg = bresp;
        exp_aw.push_back('{addr, len, size, 32'hCAFE_0000 | addr, len[0], w_before});
        for (int i = 0; i <= int'(len); i++) begin
            exp_w.push_back('{32'hC0DE_0000 + 32'(i), strb, (i == int'(len))});
        end
        exp_resp.push_back('{exp_err, -1});
        apply_stimulus(1'b1, addr, len, size);
        for (int i = 0; i <= int'(len); i++) send_w_beat(32'hC0DE_0000 + 32'(i), strb);
        wr_dv = 1'b0;
        wait_resp(100, 1'b0);
        aw_delay  = 0;
        bresp_cfg = 2'b00;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int err_beat, input logic exp_err, input logic rej, input logic toggle);
        r_err_beat = err_beat;
        if (rej) begin
            exp_resp.push_back('{exp_err, cyc + 1});
        end else begin
            exp_ar.push_back('{addr, len, size, 32'hCAFE_0000 | addr, len[0], -1});
            for (int i = 0; i <= int'(len); i++) begin
                exp_rd.push_back('{32'h5A5A_0000 | (addr + 32'(i * 4)), (i == int'(len))});
            end
            exp_resp.push_back('{exp_err, -1});
        end
        apply_stimulus(1'b0, addr, len, size);
        wait_resp(1200, toggle);
        r_err_beat = -1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_dv    = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_size  = '0;
        req_user  = '0;
        req_id    = '0;
        wr_dv     = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        rd_hld    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_hld", 64'(req_hld), 64'(0));
        check_output("rst_resp_dv", 64'(resp_dv), 64'(0));
        check_output("rst_resp_err", 64'(resp_err), 64'(0));
        check_output("rst_awvalid", 64'(axi.awvalid), 64'(0));
        check_output("rst_arvalid", 64'(axi.arvalid), 64'(0));
        check_output("rst_wvalid", 64'(axi.wvalid), 64'(0));
        check_output("rst_bready", 64'(axi.bready), 64'(0));
        check_output("rst_rready", 64'(axi.rready), 64'(0));
        check_output("rst_rd_dv", 64'(rd_dv), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single-beat write");
        do_write(32'h100, 8'd0, 3'd2, 4'hF, 0, 2'b00, 1'b0, -1);
        $display("[TB] read len=3 with rd_hld toggling");
        do_read(32'h0, 8'd3, 3'd2, -1, 1'b0, 1'b0, 1'b1);
        $display("[TB] write len=3 with AW delayed");
        do_write(32'h200, 8'd3, 3'd2, 4'h3, 5, 2'b00, 1'b0, 4);
        $display("[TB] rejected requests");
        do_read(32'hFF8, 8'd3, 3'd2, -1, 1'b1, 1'b1, 1'b0);
        do_read(32'h0, 8'd0, 3'd3, -1, 1'b1, 1'b1, 1'b0);
        $display("[TB] read ending exactly on a 4KB boundary");
        do_read(32'hFF0, 8'd3, 3'd2, -1, 1'b0, 1'b0, 1'b0);
        $display("[TB] error responses");
        do_read(32'h40, 8'd3, 3'd2, 1, 1'b1, 1'b0, 1'b0);
        do_write(32'h300, 8'd1, 3'd2, 4'hF, 0, 2'b11, 1'b1, -1);
        do_write(32'h380, 8'd0, 3'd2, 4'hF, 0, 2'b01, 1'b0, -1);
        $display("[TB] write len=255");
        do_write(32'h1000, 8'd255, 3'd2, 4'hF, 0, 2'b00, 1'b0, -1);

        $display("[TB] reset mid-burst");
        aw_delay = 50;
        exp_w.push_back('{32'hC0DE_0000, 4'hF, 1'b0});
        exp_w.push_back('{32'hC0DE_0001, 4'hF, 1'b0});
        apply_stimulus(1'b1, 32'h400, 8'd7, 3'd2);
        send_w_beat(32'hC0DE_0000, 4'hF);
        send_w_beat(32'hC0DE_0001, 4'hF);
        wdata = 32'hC0DE_0002;
        check_output("awvalid_before_rst", 64'(axi.awvalid), 64'(1));
        check_output("wvalid_before_rst", 64'(axi.wvalid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_output("async_awvalid", 64'(axi.awvalid), 64'(0));
        check_output("async_wvalid", 64'(axi.wvalid), 64'(0));
        check_output("async_arvalid", 64'(axi.arvalid), 64'(0));
        check_output("async_req_hld", 64'(req_hld), 64'(0));
        check_output("async_resp_dv", 64'(resp_dv), 64'(0));
        check_output("w_q_after_rst", 64'(exp_w.size()), 64'(0));
        wr_dv = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        aw_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] read after reset");
        do_read(32'h80, 8'd1, 3'd2, -1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        check_output("aw_q_empty", 64'(exp_aw.size()), 64'(0));
        check_output("ar_q_empty", 64'(exp_ar.size()), 64'(0));
        check_output("w_q_empty", 64'(exp_w.size()), 64'(0));
        check_output("rd_q_empty", 64'(exp_rd.size()), 64'(0));
        check_output("resp_q_empty", 64'(exp_resp.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
